// File: rtl/sram_arbiter.sv
// sram_arbiter: two-master SRAM request arbiter, master 1 priority with starvation guard, tagged registered read return
module sram_arbiter #(
  parameter int AW = 18,
  parameter int DW = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_read,
  input  logic          p0_write,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  input  logic [DW/8-1:0] p0_strobe,
  output logic          p0_ready,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_read,
  input  logic [AW-1:0] p1_addr,
  output logic          p1_ready,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [DW/8-1:0] mem_strobe,
  input  logic [DW-1:0] mem_rdata
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve;
  logic p0_req, p1_req, grant_p0, grant_p1;
  logic tag_v, tag_p;
  always_comb begin
    p0_req = p0_read | p0_write;
    p1_req = p1_read;
    grant_p1 = p1_req && !(p0_req && starve == SW'(STARVE_MAX));
    grant_p0 = !grant_p1 && p0_req;
    p0_ready = grant_p0;
    p1_ready = grant_p1;
    mem_write = grant_p0 && p0_write;
    mem_read = grant_p1 || (grant_p0 && !p0_write);
    mem_addr = grant_p1 ? p1_addr : p0_addr;
    mem_strobe = grant_p1 ? {(DW/8){1'b1}} : p0_strobe;
    mem_wdata = p0_wdata;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      starve <= '0;
      tag_v <= 1'b0;
      tag_p <= 1'b0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_rdata <= '0;
      p1_rdata <= '0;
    end else begin
      starve <= (grant_p1 && p0_req) ? ((starve == SW'(STARVE_MAX)) ? starve : starve + SW'(1)) : '0;
      tag_v <= mem_read;
      tag_p <= grant_p1;
      p0_rvalid <= tag_v && !tag_p;
      p1_rvalid <= tag_v && tag_p;
      if (tag_v && !tag_p) p0_rdata <= mem_rdata;
      if (tag_v && tag_p) p1_rdata <= mem_rdata;
    end
  end
endmodule
